// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions: hazard controller state encoding and register-file constants.
package core_pkg;

  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} hz_state_t;

  localparam logic [3:0] REG_ZERO  = 4'h0;
  localparam int         NUM_REGS  = 16;
  localparam int         REG_IDX_W = $clog2(NUM_REGS);

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register write-enable / flush bundle between the hazard controller and the datapath.
interface hazard_ctrl_if;
  logic PC_wen;
  logic IF_ID_wen;
  logic IF_ID_flush;
  logic ID_EX_wen;
  logic ID_EX_flush;
  logic EX_MEM_wen;
  logic MEM_WB_wen;

  modport master (output PC_wen, IF_ID_wen, IF_ID_flush, ID_EX_wen, ID_EX_flush,
                         EX_MEM_wen, MEM_WB_wen);
  modport slave  (input  PC_wen, IF_ID_wen, IF_ID_flush, ID_EX_wen, ID_EX_flush,
                         EX_MEM_wen, MEM_WB_wen);
endinterface

// File: rtl/perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use, branch flush, memory stalls, HLT drain.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] ID_Rs,
  input  logic [REG_IDX_W-1:0] ID_Rt,
  input  logic                 ID_uses_rs,
  input  logic                 ID_uses_rt,
  input  logic                 ID_Branch_taken,
  input  logic                 ID_Halt,
  input  logic                 EX_MemtoReg,
  input  logic [REG_IDX_W-1:0] EX_Rd,
  input  logic                 IMem_stall,
  input  logic                 DMem_stall,
  hazard_ctrl_if.master        pif,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  hz_state_t  state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;
  logic       lu;
  logic       pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen, mem_wb_wen;

  assign lu = EX_MemtoReg && (EX_Rd != REG_ZERO) &&
              ((ID_uses_rs && (ID_Rs == EX_Rd)) || (ID_uses_rt && (ID_Rt == EX_Rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    pc_wen        = 1'b1;
    if_id_wen     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_wen     = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_wen    = 1'b1;
    mem_wb_wen    = 1'b1;
    halted        = 1'b0;
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    if (rst_n) begin
      unique case (state)
        HALTED: begin
          {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = '0;
          halted = 1'b1;
        end
        DRAIN: begin
          if (DMem_stall) begin
            {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = '0;
          end else begin
            pc_wen        = 1'b0;
            if_id_wen     = 1'b0;
            id_ex_flush   = 1'b1;
            drain_cnt_nxt = drain_cnt + 4'd1;
            if (drain_cnt_nxt == 4'(DRAIN_CYCLES)) state_nxt = HALTED;
          end
        end
        default: begin
          // MEMWAIT with the data memory released behaves exactly like RUN
          state_nxt = RUN;
          if (DMem_stall) begin
            {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = '0;
            state_nxt = MEMWAIT;
          end else if (IMem_stall) begin
            pc_wen      = 1'b0;
            if_id_flush = 1'b1;
          end else if (ID_Halt) begin
            pc_wen        = 1'b0;
            if_id_wen     = 1'b0;
            id_ex_flush   = 1'b1;
            state_nxt     = DRAIN;
            drain_cnt_nxt = 4'd1;
          end else if (lu) begin
            // one bubble is enough: the load leaves EX on the next edge
            pc_wen      = 1'b0;
            if_id_wen   = 1'b0;
            id_ex_flush = 1'b1;
          end else if (ID_Branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
      endcase
    end
  end

  assign pif.PC_wen      = pc_wen;
  assign pif.IF_ID_wen   = if_id_wen;
  assign pif.IF_ID_flush = if_id_flush;
  assign pif.ID_EX_wen   = id_ex_wen;
  assign pif.ID_EX_flush = id_ex_flush;
  assign pif.EX_MEM_wen  = ex_mem_wen;
  assign pif.MEM_WB_wen  = mem_wb_wen;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!pc_wen && (state != HALTED)),
    .cnt   (stall_cycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if_id_flush),
    .cnt   (flush_count)
  );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 16-bit 5-stage core.
- Initiator side of the pipeline-register write-enable/flush interface: drives wen/flush of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Detects load-use hazards, taken-branch flushes, instruction/data memory stalls and HLT drain.
- Keeps two 16-bit performance counters.

Parameters:
- DRAIN_CYCLES, 4, cycles after HLT decode before the core reports halted (3..15 legal).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- ID_Rs  in  4  source register 1 of the instruction in ID
- ID_Rt  in  4  source register 2 of the instruction in ID
- ID_uses_rs  in  1  ID instruction reads Rs
- ID_uses_rt  in  1  ID instruction reads Rt
- ID_Branch_taken  in  1  branch resolved taken in ID this cycle
- ID_Halt  in  1  HLT opcode in ID
- EX_MemtoReg  in  1  instruction in EX is a load
- EX_Rd  in  4  destination register of the instruction in EX
- IMem_stall  in  1  instruction memory busy (fetch miss)
- DMem_stall  in  1  data memory busy
- PC_wen  out  1  PC register write enable
- IF_ID_wen  out  1  IF_ID write enable
- IF_ID_flush  out  1  load NOP into IF_ID at next edge
- ID_EX_wen  out  1  ID_EX write enable
- ID_EX_flush  out  1  load bubble (all control zero) into ID_EX
- EX_MEM_wen  out  1  EX_MEM write enable
- MEM_WB_wen  out  1  MEM_WB write enable
- halted  out  1  core halted
- stall_cycles  out  CNT_W  count of PC-frozen cycles
- flush_count  out  CNT_W  count of IF_ID flushes

Behaviour:
- States: RUN, MEMWAIT, DRAIN, HALTED. Reset enters RUN; drain counter = 0; both perf counters = 0.
- Outputs are combinational from state and inputs; only state, drain counter and perf counters are registered.
- RUN outputs with no hazard: all wen = 1, both flush = 0, halted = 0. These are also the values while rst_n is low.
- Load-use hazard (LU) = EX_MemtoReg && EX_Rd != 0 && ((ID_uses_rs && ID_Rs == EX_Rd) || (ID_uses_rt && ID_Rt == EX_Rd)). R0 never hazards.
- Priority, highest first: DMem_stall, IMem_stall, ID_Halt, LU, ID_Branch_taken.
- DMem_stall = 1 (any state except HALTED):
  - All wen = 0, flushes = 0.
  - RUN -> MEMWAIT. MEMWAIT holds while DMem_stall = 1, then returns to RUN when it drops.
  - In DRAIN, the state and counter freeze instead.
- IMem_stall (RUN only): PC_wen = 0, IF_ID_flush = 1, all other wen = 1.
- ID_Halt (RUN):
  - PC_wen = 0, IF_ID_wen = 0, ID_EX_flush = 1.
  - Next state DRAIN, counter = 1.
- DRAIN:
  - Outputs as for halt; counter increments each unstalled cycle.
  - When counter == DRAIN_CYCLES -> HALTED.
- HALTED:
  - All wen = 0, flushes = 0, halted = 1.
  - Ignores all inputs; exits only via reset.
- LU (RUN): PC_wen = 0, IF_ID_wen = 0, ID_EX_wen = 1 with ID_EX_flush = 1. No state change.
  - Exactly one stall cycle results, because the load leaves EX next edge.
- ID_Branch_taken (RUN, no LU): IF_ID_flush = 1, PC_wen = 1. A taken branch coinciding with LU is ignored this cycle; ID re-resolves it next cycle.
- stall_cycles: +1 on every cycle with PC_wen = 0 and state != HALTED.
- flush_count: +1 on every cycle with IF_ID_flush = 1.
- Both perf counters wrap modulo 2^CNT_W.
- Reset asserted mid-DRAIN or in MEMWAIT returns to RUN immediately (asynchronous) and clears the counters.

Decomposition:
- Shared package core_pkg holds:
  - state enum hz_state_t {RUN, MEMWAIT, DRAIN, HALTED};
  - REG_ZERO = 4'h0;
  - NUM_REGS = 16.
- One sub-module, perf_counter (CNT_W-bit, enable, wrap), instantiated twice.
- The hazard compare stays inline.

Test Plan:
- Reset release, idle inputs -> all wen = 1, flushes = 0, halted = 0, stall_cycles = 0, flush_count = 0.
- EX_MemtoReg = 1, EX_Rd = 3, ID_Rs = 3, ID_uses_rs = 1 for one cycle -> PC_wen = 0, IF_ID_wen = 0, ID_EX_flush = 1 that cycle only; stall_cycles = 1. Same stimulus with EX_Rd = 0 -> no stall.
- ID_Branch_taken = 1 for one cycle -> IF_ID_flush = 1, PC_wen = 1; flush_count = 1.
- DMem_stall = 1 for 3 cycles during RUN -> all wen = 0 for 3 cycles; state MEMWAIT, then RUN; stall_cycles += 3.
- ID_Halt = 1 with DRAIN_CYCLES = 4, DMem_stall = 1 for 2 cycles mid-drain -> halted rises 6 cycles after HLT decode; all wen = 0 thereafter.
- LU, ID_Branch_taken and IMem_stall asserted together -> IMem_stall wins: PC_wen = 0, IF_ID_flush = 1, ID_EX_flush = 0; rst_n pulsed in HALTED -> RUN, halted = 0.
